raw_frame_packer: RTL and testbench

Downstream stage of the CMOS RAW/Gray capture block. Consumes its synchronised `vsync`/`href`/8-bit pixel stream on `cmos_pclk` and crops a programmable window. Packs four consecutive pixels into one 32-bit word and writes it to the async write FIFO feeding the frame-buffer DMA. Per frame, it reports start and done pulses, a frame counter, and FIFO-overflow status.

---
 rtl/raw_pack_pkg.sv | 9 +
 rtl/raw_window_counter.sv | 61 ++++++
 rtl/raw_frame_packer.sv | 131 +++++++++++++
 tb/tb_raw_frame_packer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/raw_pack_pkg.sv
// Shared widths and FSM state type for the RAW/Gray frame packer.
package raw_pack_pkg;
  localparam int PIX_W  = 8;
  localparam int WORD_W = 32;
  localparam int CNT_W  = 12;
  localparam int FCNT_W = 16;

  typedef enum logic [1:0] {IDLE, ACTIVE, DROP} state_t;
endpackage

// File: rtl/raw_window_counter.sv
// Sync edge detection, column/row counters and crop-window decode for the
// incoming CMOS pixel stream.
import raw_pack_pkg::*;

module raw_window_counter #(
  parameter logic [CNT_W-1:0] H_START  = 12'd0,
  parameter logic [CNT_W-1:0] H_ACTIVE = 12'd1280,
  parameter logic [CNT_W-1:0] V_START  = 12'd0,
  parameter logic [CNT_W-1:0] V_ACTIVE = 12'd720
) (
  input  logic cmos_pclk,
  input  logic rst_n,
  input  logic in_vsync,
  input  logic in_href,
  output logic vs_rise,
  output logic vs_fall,
  output logic in_window
);

  localparam logic [CNT_W:0] H_LO = {1'b0, H_START};
  localparam logic [CNT_W:0] H_HI = {1'b0, H_START} + {1'b0, H_ACTIVE};
  localparam logic [CNT_W:0] V_LO = {1'b0, V_START};
  localparam logic [CNT_W:0] V_HI = {1'b0, V_START} + {1'b0, V_ACTIVE};

  logic             vs_d;
  logic             hs_d;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             href_fall;

  assign vs_rise   = in_vsync & ~vs_d;
  assign vs_fall   = ~in_vsync & vs_d;
  assign href_fall = hs_d & ~in_href & in_vsync;

  // vs_d resets high so a frame already running at reset release never
  // looks like a fresh vsync rise.
  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d <= 1'b1;
      hs_d <= 1'b0;
      x    <= '0;
      y    <= '0;
    end else begin
      vs_d <= in_vsync;
      hs_d <= in_href;
      if (!in_href)
        x <= '0;
      else if (in_vsync && x != '1)
        x <= x + CNT_W'(1);
      if (!in_vsync)
        y <= '0;
      else if (href_fall && y != '1)
        y <= y + CNT_W'(1);
    end
  end

  assign in_window = in_vsync & in_href
                   & ({1'b0, x} >= H_LO) & ({1'b0, x} < H_HI)
                   & ({1'b0, y} >= V_LO) & ({1'b0, y} < V_HI);

endmodule

// File: rtl/raw_frame_packer.sv
// Crops the CMOS pixel stream to a window and packs 4 pixels per 32-bit
// FIFO word; reports frame start/done, frame count and overflow.
import raw_pack_pkg::*;

module raw_frame_packer #(
  parameter logic [CNT_W-1:0] H_START  = 12'd0,
  parameter logic [CNT_W-1:0] H_ACTIVE = 12'd1280,
  parameter logic [CNT_W-1:0] V_START  = 12'd0,
  parameter logic [CNT_W-1:0] V_ACTIVE = 12'd720
) (
  input  logic              cmos_pclk,
  input  logic              rst_n,
  input  logic              in_vsync,
  input  logic              in_href,
  input  logic [PIX_W-1:0]  in_data,
  input  logic              fifo_full,
  output logic              fifo_wr_en,
  output logic [WORD_W-1:0] fifo_wr_data,
  output logic              frame_start,
  output logic              frame_done,
  output logic              overflow,
  output logic [FCNT_W-1:0] frame_cnt
);

  state_t              state, state_nxt;
  logic                vs_rise, vs_fall, in_window;
  logic [1:0]          lane;
  logic [3*PIX_W-1:0]  pack;
  logic                grp_done;
  logic                wr_en_nxt, start_nxt, done_nxt, ovf_nxt;
  logic [WORD_W-1:0]   data_nxt;
  logic [FCNT_W-1:0]   cnt_nxt;

  raw_window_counter #(
    .H_START (H_START),
    .H_ACTIVE(H_ACTIVE),
    .V_START (V_START),
    .V_ACTIVE(V_ACTIVE)
  ) u_win (
    .cmos_pclk(cmos_pclk),
    .rst_n    (rst_n),
    .in_vsync (in_vsync),
    .in_href  (in_href),
    .vs_rise  (vs_rise),
    .vs_fall  (vs_fall),
    .in_window(in_window)
  );

  assign grp_done = in_window && (lane == 2'd3);

  // Lane packer: a partial group is dropped because lane clears with href.
  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      lane <= '0;
      pack <= '0;
    end else if (!in_href) begin
      lane <= '0;
    end else if (in_window) begin
      lane <= lane + 2'd1;
      case (lane)
        2'd0:    pack[PIX_W-1:0]         <= in_data;
        2'd1:    pack[2*PIX_W-1:PIX_W]   <= in_data;
        2'd2:    pack[3*PIX_W-1:2*PIX_W] <= in_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    wr_en_nxt = 1'b0;
    data_nxt  = fifo_wr_data;
    start_nxt = 1'b0;
    done_nxt  = 1'b0;
    ovf_nxt   = overflow;
    cnt_nxt   = frame_cnt;
    case (state)
      IDLE: begin
        if (vs_rise) begin
          state_nxt = ACTIVE;
          start_nxt = 1'b1;
          ovf_nxt   = 1'b0;
        end
      end
      ACTIVE: begin
        if (vs_fall) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          cnt_nxt   = frame_cnt + FCNT_W'(1);
        end else if (grp_done) begin
          if (!fifo_full) begin
            wr_en_nxt = 1'b1;
            data_nxt  = {in_data, pack};
          end else begin
            ovf_nxt   = 1'b1;
            state_nxt = DROP;
          end
        end
      end
      DROP: begin
        if (vs_fall) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          cnt_nxt   = frame_cnt + FCNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
      frame_start  <= 1'b0;
      frame_done   <= 1'b0;
      overflow     <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      state        <= state_nxt;
      fifo_wr_en   <= wr_en_nxt;
      fifo_wr_data <= data_nxt;
      frame_start  <= start_nxt;
      frame_done   <= done_nxt;
      overflow     <= ovf_nxt;
      frame_cnt    <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_raw_frame_packer.sv
// Directed bench for raw_frame_packer: two windows, FIFO-full drop, reset
// behaviour and frame counter wrap.
module tb_raw_frame_packer;

  logic        cmos_pclk = 1'b0;
  logic        rst_n     = 1'b0;
  logic        in_vsync  = 1'b0;
  logic        in_href   = 1'b0;
  logic [7:0]  in_data   = 8'd0;
  logic        fifo_full = 1'b0;

  logic        a_wr_en, a_start, a_done, a_ovf;
  logic [31:0] a_data;
  logic [15:0] a_cnt;
  logic        b_wr_en, b_start, b_done, b_ovf;
  logic [31:0] b_data;
  logic [15:0] b_cnt;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int starts_a, dones_a, first_wr, last_wr, min_gap, pix3_cyc;
  logic ovf_at_start;
  logic [31:0] exp_w[4];

  always #5 cmos_pclk = ~cmos_pclk;
  always @(posedge cmos_pclk) cyc <= cyc + 1;

  raw_frame_packer #(
    .H_START(12'd0), .H_ACTIVE(12'd8), .V_START(12'd0), .V_ACTIVE(12'd2)
  ) dut_a (
    .cmos_pclk(cmos_pclk), .rst_n(rst_n), .in_vsync(in_vsync),
    .in_href(in_href), .in_data(in_data), .fifo_full(fifo_full),
    .fifo_wr_en(a_wr_en), .fifo_wr_data(a_data), .frame_start(a_start),
    .frame_done(a_done), .overflow(a_ovf), .frame_cnt(a_cnt)
  );

  raw_frame_packer #(
    .H_START(12'd2), .H_ACTIVE(12'd4), .V_START(12'd1), .V_ACTIVE(12'd1)
  ) dut_b (
    .cmos_pclk(cmos_pclk), .rst_n(rst_n), .in_vsync(in_vsync),
    .in_href(in_href), .in_data(in_data), .fifo_full(fifo_full),
    .fifo_wr_en(b_wr_en), .fifo_wr_data(b_data), .frame_start(b_start),
    .frame_done(b_done), .overflow(b_ovf), .frame_cnt(b_cnt)
  );

  always @(negedge cmos_pclk) begin
    if (rst_n) begin
      if (a_wr_en) begin
        qa.push_back(a_data);
        if (last_wr >= 0 && (cyc - last_wr) < min_gap) min_gap = cyc - last_wr;
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
      end
      if (a_start) begin
        starts_a++;
        ovf_at_start = a_ovf;
      end
      if (a_done) dones_a++;
      if (b_wr_en) qb.push_back(b_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge cmos_pclk);
    #1;
  endtask

  task automatic clear_mon();
    qa.delete();
    qb.delete();
    starts_a = 0;
    dones_a  = 0;
    first_wr = -1;
    last_wr  = -1;
    min_gap  = 1000;
    ovf_at_start = 1'bx;
  endtask

  // mode 0: pixels count 1,2,3.. across the frame; mode 1: line n pixel k = 16n+k
  task automatic drive_frame(input int nlines, input int mode, input int full_at);
    int pix = 0;
    in_vsync = 1'b1;
    tick(2);
    for (int l = 0; l < nlines; l++) begin
      for (int k = 0; k < 8; k++) begin
        in_href   = 1'b1;
        in_data   = (mode == 0) ? 8'(pix + 1) : 8'(16 * l + k);
        fifo_full = (pix == full_at);
        if (pix == 3) pix3_cyc = cyc;
        pix++;
        tick(1);
      end
      in_href   = 1'b0;
      in_data   = 8'd0;
      fifo_full = 1'b0;
      tick(4);
    end
    in_vsync = 1'b0;
    tick(4);
  endtask

  function automatic logic [31:0] qa_at(input int i);
    return (i < qa.size()) ? qa[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_wr_en"}, 32'(a_wr_en), 32'd0);
    chk({tag, "_wr_data"}, a_data, 32'd0);
    chk({tag, "_start"}, 32'(a_start), 32'd0);
    chk({tag, "_done"}, 32'(a_done), 32'd0);
    chk({tag, "_ovf"}, 32'(a_ovf), 32'd0);
    chk({tag, "_cnt"}, 32'(a_cnt), 32'd0);
  endtask

  initial begin
    clear_mon();
    pix3_cyc = -1;
    tick(3);
    chk_reset_outs("rst");
    rst_n = 1'b1;
    tick(3);

    // Basic 8x2 capture
    exp_w[0] = 32'h04030201; exp_w[1] = 32'h08070605;
    exp_w[2] = 32'h0C0B0A09; exp_w[3] = 32'h100F0E0D;
    clear_mon();
    drive_frame(2, 0, -1);
    chk("t1_nwr", 32'(qa.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("t1_word%0d", i), qa_at(i), exp_w[i]);
    chk("t1_starts", 32'(starts_a), 32'd1);
    chk("t1_dones", 32'(dones_a), 32'd1);
    chk("t1_cnt", 32'(a_cnt), 32'd1);
    chk("t1_wr_latency", 32'(first_wr - pix3_cyc), 32'd1);
    chk("t1_min_gap", 32'(min_gap), 32'd4);

    // Offset window on dut_b
    clear_mon();
    drive_frame(3, 1, -1);
    chk("t2_nwr", 32'(qb.size()), 32'd1);
    chk("t2_word", (qb.size() > 0) ? qb[0] : 32'hDEAD_BEEF, 32'h15141312);
    chk("t2_cnt_b", 32'(b_cnt), 32'd2);

    // FIFO full on the second write, then a clean frame
    clear_mon();
    drive_frame(2, 0, 7);
    chk("t3_f1_nwr", 32'(qa.size()), 32'd1);
    chk("t3_f1_word", qa_at(0), 32'h04030201);
    chk("t3_f1_ovf", 32'(a_ovf), 32'd1);
    chk("t3_f1_done", 32'(dones_a), 32'd1);
    clear_mon();
    drive_frame(2, 0, -1);
    chk("t3_f2_ovf_at_start", 32'(ovf_at_start), 32'd0);
    chk("t3_f2_nwr", 32'(qa.size()), 32'd4);
    chk("t3_f2_word3", qa_at(3), 32'h100F0E0D);
    chk("t3_f2_ovf", 32'(a_ovf), 32'd0);
    chk("t3_f2_cnt", 32'(a_cnt), 32'd4);

    // Reset released mid-frame: that frame is ignored
    in_vsync = 1'b1;
    tick(2);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    clear_mon();
    for (int k = 0; k < 8; k++) begin
      in_href = 1'b1;
      in_data = 8'(k + 1);
      tick(1);
    end
    in_href = 1'b0;
    tick(4);
    in_vsync = 1'b0;
    tick(4);
    chk("t4_skip_starts", 32'(starts_a), 32'd0);
    chk("t4_skip_nwr", 32'(qa.size()), 32'd0);
    chk("t4_skip_dones", 32'(dones_a), 32'd0);
    clear_mon();
    drive_frame(2, 0, -1);
    chk("t4_nwr", 32'(qa.size()), 32'd4);
    chk("t4_word0", qa_at(0), 32'h04030201);
    chk("t4_cnt", 32'(a_cnt), 32'd1);

    // Reset mid-line in ACTIVE, then counter wrap
    in_vsync = 1'b1;
    tick(2);
    for (int k = 0; k < 5; k++) begin
      in_href = 1'b1;
      in_data = 8'(k + 1);
      tick(1);
    end
    clear_mon();
    rst_n = 1'b0;
    #2;
    chk_reset_outs("t5_rst");
    in_href  = 1'b0;
    in_vsync = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    chk("t5_no_done", 32'(dones_a), 32'd0);
    clear_mon();
    for (int f = 0; f < 65537; f++) begin
      in_vsync = 1'b1;
      tick(1);
      in_vsync = 1'b0;
      tick(1);
    end
    tick(3);
    chk("t5_dones", 32'(dones_a), 32'd65537);
    chk("t5_cnt_wrap", 32'(a_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
